// File: rtl/spi_pkg.sv
// Shared SPI definitions: engine state encoding and widths common with the register block.
package spi_pkg;

  localparam int SPI_DATA_W = 32;
  localparam int SPI_N_CS   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] count;

  assign tick = en && (count == 8'd0);

  // Held at the reload value while disabled so the first tick lands CLK_DIV cycles after enable.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= RELOAD;
    end else if (!en || count == 8'd0) begin
      count <= RELOAD;
    end else begin
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: one MSB-first DATA_W-bit transfer per rising edge of start_i,
// with one of N_CS active-low chip selects asserted for the whole transfer.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = SPI_DATA_W,
  parameter int N_CS    = SPI_N_CS
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [DATA_W-1:0]       dat_i,
  input  logic                    start_i,
  input  logic [$clog2(N_CS)-1:0] sel_i,
  output logic [DATA_W-1:0]       dat_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    sclk_o,
  output logic                    mosi_o,
  input  logic                    miso_i,
  output logic [N_CS-1:0]         cs_n_o
);

  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
  localparam logic [5:0] ALL_BITS = 6'(DATA_W);

  state_t            state;
  logic              start_reg;
  logic              start_prev;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [5:0]        bit_cnt;
  logic              div_en;
  logic              tick;

  assign div_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign mosi_o = tx_sr[DATA_W-1];

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en     (div_en),
    .tick   (tick)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      start_reg  <= 1'b0;
      start_prev <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      dat_o      <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      sclk_o     <= 1'b0;
      cs_n_o     <= '1;
    end else begin
      start_reg  <= start_i;
      start_prev <= start_reg;
      case (state)
        IDLE: begin
          if (start_reg && !start_prev) begin
            tx_sr   <= dat_i;
            bit_cnt <= '0;
            cs_n_o  <= ~(N_CS'(1) << sel_i);
            busy_o  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          // The setup period ends on the first SCLK rise.
          if (tick) begin
            sclk_o <= 1'b1;
            rx_sr  <= {rx_sr[DATA_W-2:0], miso_i};
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk_o) begin
              sclk_o  <= 1'b0;
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt != LAST_BIT) begin
                tx_sr <= tx_sr << 1;
              end
            end else if (bit_cnt == ALL_BITS) begin
              // Trailing low half of the final SCLK period has elapsed.
              state <= HOLD;
            end else begin
              sclk_o <= 1'b1;
              rx_sr  <= {rx_sr[DATA_W-2:0], miso_i};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_o <= '1;
            dat_o  <= rx_sr;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!start_reg) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

SPI master that sits directly downstream of the Wishbone control-register block. It consumes the 32-bit transmit word, start level and 2-bit slave select driven by that block, and returns the received word and a done flag to it. It performs one 32-bit mode-0 (CPOL=0, CPHA=0), MSB-first transfer per start request and drives one of four active-low chip selects.

## Interface
- CLK_DIV, 4, clk_i cycles per SCLK half-period; legal range 2..255.
- DATA_W, 32, transfer length in bits; fixed shift-register width.
- N_CS, 4, number of chip selects; must equal 2**width(sel_i).

- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- dat_i  in  DATA_W  word to transmit; sampled at start.
- start_i  in  1  start request level; held by software until done_o is seen.
- sel_i  in  2  slave index; sampled at start.
- dat_o  out  DATA_W  last received word.
- done_o  out  1  transfer complete flag.
- busy_o  out  1  high from start acceptance until done_o rises.
- sclk_o  out  1  SPI clock, idle low.
- mosi_o  out  1  SPI data out.
- miso_i  in  1  SPI data in.
- cs_n_o  out  N_CS  active-low chip selects; at most one low at a time.

## Operation
- Reset values: dat_o=0, done_o=0, busy_o=0, sclk_o=0, mosi_o=0, cs_n_o=all ones, state=IDLE. All outputs take these values immediately when reset_i asserts, including mid-transfer.
- The block registers start_i internally. A transfer starts only on a 0→1 edge. A level held high after done_o never re-triggers.
- States and transitions:
  - IDLE: on the start edge, load the shift register from dat_i and latch sel_i. Drive cs_n_o[sel]=0 and mosi_o=dat_i[DATA_W-1]. Go to SETUP.
  - SETUP: wait CLK_DIV cycles with sclk_o low, then go to SHIFT.
  - SHIFT: DATA_W SCLK periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
    - On the clk_i edge that drives sclk_o 0→1, sample miso_i into the receive shift register LSB.
    - On the edge that drives sclk_o 1→0, shift mosi_o to the next bit. No shift after the last bit; mosi_o holds its value.
    - After the DATA_W-th falling edge, go to HOLD.
  - HOLD: wait CLK_DIV cycles with sclk_o low and CS still asserted. Then deassert all cs_n_o, copy the receive register to dat_o, set done_o=1, clear busy_o, and go to DONE.
  - DONE: hold done_o=1 while start_i=1. When start_i is sampled 0, clear done_o and go to IDLE.
- start_i dropping during SETUP/SHIFT/HOLD is ignored; the transfer completes. If start_i is already 0 on entry to DONE, done_o is high for exactly one cycle.
- Changes to dat_i or sel_i after start acceptance have no effect on the current transfer.
- dat_o changes only on HOLD→DONE and otherwise holds its value.

## Timing
- Start acceptance: cs_n_o falls and busy_o rises 1 cycle after the clk_i edge that first samples start_i=1.
- Edge spacing: first sclk_o rise comes CLK_DIV cycles after cs_n_o falls. Consecutive rising edges are 2*CLK_DIV cycles apart.
- done_o rises exactly (2*DATA_W+2)*CLK_DIV+1 cycles after the first start_i=1 sample; with defaults this is 265 cycles.
- done_o falls 1 cycle after start_i is sampled 0 in DONE.
- The earliest next start edge is accepted from IDLE, one cycle after that.
- miso_i is used unsynchronised; the slave must hold data stable for at least one clk_i cycle around each sclk_o rise.

## Structure
- Shared package spi_pkg contains:
  - state enum (IDLE, SETUP, SHIFT, HOLD, DONE), 3-bit encoding;
  - SPI_DATA_W=32 and SPI_N_CS=4 constants, shared with the register block.
- One sub-module, spi_clk_div:
  - down-counter reloaded to CLK_DIV-1;
  - emits a one-cycle half-period tick;
  - enable input forces a reload when low.
- The engine FSM, bit counter (6 bits) and both shift registers live in the top module.

## Test plan
- Defaults, sel_i=2, dat_i=0xA5C3_0F81, miso looped back to mosi:
  - only cs_n_o[2] goes low, for the whole transfer;
  - 32 sclk rises, first one 5 cycles after start sampling;
  - done_o at cycle 265; dat_o=0xA5C3_0F81; busy_o low at done.
- Slave model drives 0x1234_5678 MSB-first, changing on falling edges: dat_o=0x1234_5678; mosi_o bit order matches dat_i MSB-first.
- start_i held high for 400 cycles after done_o: exactly one transfer occurs and done_o stays high. Drop start_i: done_o clears 1 cycle later. Re-raise start_i: a second transfer follows.
- start_i pulsed high for 1 cycle only: the transfer completes and done_o is high for exactly 1 cycle.
- reset_i asserted at SHIFT bit 10: same cycle, cs_n_o=4'hF, sclk_o=0, busy_o=0. dat_o keeps its pre-reset value of 0; no done_o.
- CLK_DIV=2, back-to-back transfers: period between sclk rises is 4 cycles; done_o at cycle 133.
